// File: rtl/regs2cmd_wide_if.sv
// Register-word input and AXI-Stream command output bundle for regs2cmd_wide.
// The slave modport is the block's view; the master modport is the view of whatever drives the registers and sinks commands.
interface regs2cmd_wide_if #(
    parameter int NUM_WORDS = 2,
    parameter int WORD_W    = 32
);
    logic [NUM_WORDS*WORD_W-1:0] regs_data;
    logic [NUM_WORDS-1:0]        regs_strobe;
    logic [NUM_WORDS*WORD_W-1:0] cmd_TDATA;
    logic                        cmd_TVALID;
    logic                        cmd_TREADY;
    logic [NUM_WORDS-1:0]        pending;
    logic                        ovf_err;

    modport master (
        output regs_data,
        output regs_strobe,
        output cmd_TREADY,
        input  cmd_TDATA,
        input  cmd_TVALID,
        input  pending,
        input  ovf_err
    );

    modport slave (
        input  regs_data,
        input  regs_strobe,
        input  cmd_TREADY,
        output cmd_TDATA,
        output cmd_TVALID,
        output pending,
        output ovf_err
    );
endinterface

// File: rtl/regs2cmd_wide.sv
// Gathers NUM_WORDS strobed register words into one wide AXI-Stream command (optional REGS2CMD_WIDE_OVF_DETECT_EN adds a sticky overwrite flag).
// Latency: one cycle from the last missing word's strobe to cmd_TVALID; one command per cycle when the sink keeps up.
// Backpressure: a complete staging set waits while the output is stalled; new strobes overwrite staged words (last write wins).
module regs2cmd_wide #(
    parameter int NUM_WORDS = 2,
    parameter int WORD_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    regs2cmd_wide_if.slave bus
);
    logic [NUM_WORDS-1:0]        stg_vld;
    logic [WORD_W-1:0]           stg_dat [NUM_WORDS];
    logic [NUM_WORDS*WORD_W-1:0] stg_flat;
    logic [NUM_WORDS*WORD_W-1:0] out_dat;
    logic                        out_vld;
    logic                        stg_full;
    logic                        out_free;
    logic                        load;

    always_comb begin
        stg_flat = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            stg_flat[w*WORD_W +: WORD_W] = stg_dat[w];
        end
    end

    // The output register is free when empty or being drained on this edge.
    assign stg_full = &stg_vld;
    assign out_free = !out_vld || bus.cmd_TREADY;
    assign load     = stg_full && out_free;

    // A strobe on the load edge belongs to the next command, so it wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_vld <= '0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                stg_dat[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (bus.regs_strobe[w]) begin
                    stg_dat[w] <= bus.regs_data[w*WORD_W +: WORD_W];
                    stg_vld[w] <= 1'b1;
                end else if (load) begin
                    stg_vld[w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load) begin
            out_vld <= 1'b1;
            out_dat <= stg_flat;
        end else if (out_vld && bus.cmd_TREADY) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.cmd_TDATA  = out_dat;
    assign bus.cmd_TVALID = out_vld;
    assign bus.pending    = stg_vld;

`ifdef REGS2CMD_WIDE_OVF_DETECT_EN
    logic ovf_q;

    // An overwrite is a strobe on an already-staged word that is not being consumed this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (|(bus.regs_strobe & stg_vld) && !load) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_err = ovf_q;
`else
    assign bus.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_regs2cmd_wide.sv
// Self-checking bench for regs2cmd_wide: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_regs2cmd_wide;
    localparam int W = 32;
`ifdef REGS2CMD_WIDE_OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regs2cmd_wide_if #(.NUM_WORDS(2), .WORD_W(W)) bus2 ();
    regs2cmd_wide_if #(.NUM_WORDS(4), .WORD_W(W)) bus4 ();

    regs2cmd_wide #(.NUM_WORDS(2), .WORD_W(W)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    regs2cmd_wide #(.NUM_WORDS(4), .WORD_W(W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model for the 2-word instance: staged words with a have-mask,
    // one output slot, a sticky overwrite flag and a queue of issued commands.
    logic [W-1:0]   m_word [2];
    logic [1:0]     m_have;
    logic           m_vld;
    logic [2*W-1:0] m_dat;
    logic           m_ovf;
    logic [2*W-1:0] exp_q [$];

    function automatic void model_reset();
        m_word[0] = '0;
        m_word[1] = '0;
        m_have    = '0;
        m_vld     = 1'b0;
        m_dat     = '0;
        m_ovf     = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        logic drain;
        logic take;
        drain = m_vld && bus2.cmd_TREADY;
        take  = (m_have == 2'b11) && (!m_vld || drain);
        if (take) begin
            m_dat = {m_word[1], m_word[0]};
            exp_q.push_back(m_dat);
            m_vld = 1'b1;
        end else if (drain) begin
            m_vld = 1'b0;
        end
        for (int w = 0; w < 2; w++) begin
            if (bus2.regs_strobe[w]) begin
                if (m_have[w] && !take) m_ovf = 1'b1;
                m_word[w] = bus2.regs_data[w*W +: W];
                m_have[w] = 1'b1;
            end else if (take) begin
                m_have[w] = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        check("tvalid", bus2.cmd_TVALID, m_vld);
        if (m_vld) check("tdata", bus2.cmd_TDATA, m_dat);
        check("pending", bus2.pending, m_have);
        check("ovf_err", bus2.ovf_err, OVF_ON && m_ovf);
    endtask

    // Inputs are set on the falling edge; a tick advances one rising edge and re-checks.
    task automatic tick();
        if (bus2.cmd_TVALID === 1'b1 && bus2.cmd_TREADY === 1'b1) begin
            if (exp_q.size() == 0) check("sb_extra_beat", 1, 0);
            else check("sb_beat", bus2.cmd_TDATA, exp_q.pop_front());
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set2(input logic [1:0] stb, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic rdy);
        bus2.regs_strobe = stb;
        bus2.regs_data   = {d1, d0};
        bus2.cmd_TREADY  = rdy;
    endtask

    task automatic idle2(input logic rdy);
        set2(2'b00, '0, '0, rdy);
    endtask

    initial begin
        rst = 1'b0;
        idle2(1'b0);
        bus4.regs_strobe = '0;
        bus4.regs_data   = '0;
        bus4.cmd_TREADY  = 1'b0;
        model_reset();

        #1;
        check("rst_tvalid", bus2.cmd_TVALID, 0);
        check("rst_pending", bus2.pending, 0);
        check("rst_ovf", bus2.ovf_err, 0);
        check("rst_tdata", bus2.cmd_TDATA, 0);
        check("rst4_tvalid", bus4.cmd_TVALID, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Word0 at edge 0, word1 at edge 3: valid only after edge 4, one beat.
        set2(2'b01, 32'h11111111, '0, 1'b1);
        tick();
        idle2(1'b1);
        tick();
        tick();
        set2(2'b10, '0, 32'h22222222, 1'b1);
        tick();
        check("r28_not_yet", bus2.cmd_TVALID, 0);
        idle2(1'b1);
        tick();
        check("r28_tvalid", bus2.cmd_TVALID, 1);
        check("r28_tdata", bus2.cmd_TDATA, 64'h22222222_11111111);
        tick();
        check("r28_single_beat", bus2.cmd_TVALID, 0);

        // Stalled output: X held while Y waits complete in staging.
        set2(2'b11, 32'hA0A0A0A0, 32'hA1A1A1A1, 1'b0);
        tick();
        set2(2'b11, 32'hB0B0B0B0, 32'hB1B1B1B1, 1'b0);
        tick();
        idle2(1'b0);
        tick();
        check("r30_hold_x", bus2.cmd_TDATA, 64'hA1A1A1A1_A0A0A0A0);
        check("r30_pending", bus2.pending, 2'b11);
        idle2(1'b1);
        tick();
        check("r30_y_tvalid", bus2.cmd_TVALID, 1);
        check("r30_y_tdata", bus2.cmd_TDATA, 64'hB1B1B1B1_B0B0B0B0);
        check("r30_y_pending", bus2.pending, 2'b00);
        tick();
        check("r30_drained", bus2.cmd_TVALID, 0);

        // Strobe on the load edge starts the next command.
        set2(2'b01, 32'h0000000A, '0, 1'b0);
        tick();
        set2(2'b10, '0, 32'h0000000B, 1'b0);
        tick();
        set2(2'b01, 32'h00000007, '0, 1'b1);
        tick();
        check("r32_tdata", bus2.cmd_TDATA, 64'h0000000B_0000000A);
        check("r32_pending", bus2.pending, 2'b01);
        idle2(1'b1);
        tick();
        check("r32_pending_kept", bus2.pending, 2'b01);
        set2(2'b10, '0, 32'h00000008, 1'b1);
        tick();
        idle2(1'b1);
        tick();
        check("r32_next_tdata", bus2.cmd_TDATA, 64'h00000008_00000007);
        tick();

        // Overwrite before completion: last write wins.
        set2(2'b01, 32'h5, '0, 1'b1);
        tick();
        set2(2'b01, 32'h6, '0, 1'b1);
        tick();
        check("r31_ovf", bus2.ovf_err, OVF_ON);
        set2(2'b10, '0, 32'h99, 1'b1);
        tick();
        idle2(1'b1);
        tick();
        check("r31_tdata", bus2.cmd_TDATA, 64'h00000099_00000006);
        tick();

        // Four-word instance: all strobes at once.
        bus4.regs_strobe = 4'b1111;
        bus4.regs_data   = {32'hD, 32'hC, 32'hB, 32'hA};
        bus4.cmd_TREADY  = 1'b1;
        tick();
        bus4.regs_strobe = '0;
        check("r29_pending", bus4.pending, 4'b1111);
        check("r29_not_yet", bus4.cmd_TVALID, 0);
        tick();
        check("r29_tvalid", bus4.cmd_TVALID, 1);
        check("r29_tdata", bus4.cmd_TDATA, 128'h0000000D_0000000C_0000000B_0000000A);
        check("r29_pending_clr", bus4.pending, 4'b0000);
        tick();
        check("r29_single_beat", bus4.cmd_TVALID, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set2(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus2.regs_strobe = 2'b00;
            if (i % 50 >= 40) bus2.cmd_TREADY = 1'b0;
            tick();
        end

        // Reset during a stall with a command presented.
        set2(2'b11, 32'hDEAD0000, 32'hBEEF0000, 1'b0);
        tick();
        idle2(1'b0);
        tick();
        check("r33_pre_tvalid", bus2.cmd_TVALID, 1);
        #2;
        rst = 1'b0;
        #1;
        check("r33_tvalid", bus2.cmd_TVALID, 0);
        check("r33_pending", bus2.pending, 0);
        check("r33_ovf", bus2.ovf_err, 0);
        check("r33_tdata", bus2.cmd_TDATA, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle2(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r33_no_stale", bus2.cmd_TVALID, 0);
        end

        check("sb_outstanding", exp_q.size(), m_vld ? 1 : 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
